// File: rtl/adj_pkg.sv
// adj_pkg: shared press-FSM state type and default configuration for the
// time-adjust button conditioner.
package adj_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } adj_state_t;

  localparam int unsigned ADJ_N_BTN        = 3;
  localparam int unsigned ADJ_TICK_DIV     = 31500;  // 1 kHz tick at 31.5 MHz
  localparam int unsigned ADJ_DB_TICKS     = 8;
  localparam int unsigned ADJ_REPEAT_DELAY = 500;
  localparam int unsigned ADJ_REPEAT_RATE  = 100;

endpackage

// File: rtl/adj_debounce.sv
// adj_debounce: one button's 2-flop synchroniser, tick-based debounce counter
// and press FSM producing one-clock increment strobes.
// Auto-repeat (HELD -> REPEAT cadence) is built only when ADJ_AUTOREPEAT_EN
// is defined; otherwise a held button yields a single pulse per press.
module adj_debounce
  import adj_pkg::*;
#(
  parameter int unsigned DB_TICKS     = ADJ_DB_TICKS,
  parameter int unsigned REPEAT_DELAY = ADJ_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = ADJ_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_pulse,
  output logic o_level
);

  localparam int unsigned     DW     = $clog2(DB_TICKS + 1);
  localparam logic [DW-1:0]   DB_MAX = DW'(DB_TICKS);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_db_cnt;
  logic [DW-1:0] w_db_cnt_nxt;
  logic [DW-1:0] w_db_inc;
  logic          r_level;
  logic          w_level_nxt;
  logic          w_rise;
  logic          w_fall;
  adj_state_t    r_state;
  adj_state_t    w_state_nxt;
  logic          r_pulse;
  logic          w_pulse_nxt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_btn};
  end

  assign w_db_inc = r_db_cnt + 1'b1;

  // Debounce: count ticks of disagreement, toggle the level after DB_TICKS.
  always_comb begin
    w_db_cnt_nxt = r_db_cnt;
    w_level_nxt  = r_level;
    if (i_tick) begin
      if (r_sync[1] == r_level) begin
        w_db_cnt_nxt = '0;
      end else if (w_db_inc == DB_MAX) begin
        w_db_cnt_nxt = '0;
        w_level_nxt  = ~r_level;
      end else begin
        w_db_cnt_nxt = w_db_inc;
      end
    end
  end

  // Debounce counter and accepted level registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_db_cnt <= w_db_cnt_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Edges are taken from the next level so the press pulse is registered in
  // the same cycle that the level register becomes 1.
  assign w_rise = w_level_nxt & ~r_level;
  assign w_fall = ~w_level_nxt & r_level;

`ifdef ADJ_AUTOREPEAT_EN
  localparam int unsigned   RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   RW     = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_VAL = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RR_VAL = RW'(REPEAT_RATE);

  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_cnt_nxt;
  logic [RW-1:0] w_rep_inc;

  assign w_rep_inc = r_rep_cnt + 1'b1;

  // Press FSM next state with auto-repeat cadence.
  always_comb begin
    w_state_nxt   = r_state;
    w_pulse_nxt   = 1'b0;
    w_rep_cnt_nxt = r_rep_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt   = HELD;
          w_pulse_nxt   = 1'b1;
          w_rep_cnt_nxt = '0;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_state_nxt   = IDLE;
          w_rep_cnt_nxt = '0;
        end else if (i_tick) begin
          if (w_rep_inc == RD_VAL) begin
            w_state_nxt   = REPEAT;
            w_pulse_nxt   = 1'b1;
            w_rep_cnt_nxt = '0;
          end else begin
            w_rep_cnt_nxt = w_rep_inc;
          end
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_state_nxt   = IDLE;
          w_rep_cnt_nxt = '0;
        end else if (i_tick) begin
          if (w_rep_inc == RR_VAL) begin
            w_pulse_nxt   = 1'b1;
            w_rep_cnt_nxt = '0;
          end else begin
            w_rep_cnt_nxt = w_rep_inc;
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_rep_cnt_nxt = '0;
      end
    endcase
  end

  // Repeat counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rep_cnt <= '0;
    else          r_rep_cnt <= w_rep_cnt_nxt;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);

  // Press FSM next state: one pulse per accepted press.
  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HELD;
          w_pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        if (w_fall) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`endif

  // Press FSM state and registered pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/adj_button_conditioner.sv
// adj_button_conditioner: shared tick prescaler plus one adj_debounce per
// time-adjust button (bit 0 hours, bit 1 minutes, bit 2 seconds).
// Auto-repeat is enabled by defining ADJ_AUTOREPEAT_EN.
module adj_button_conditioner
  import adj_pkg::*;
#(
  parameter int unsigned N_BTN        = ADJ_N_BTN,
  parameter int unsigned TICK_DIV     = ADJ_TICK_DIV,
  parameter int unsigned DB_TICKS     = ADJ_DB_TICKS,
  parameter int unsigned REPEAT_DELAY = ADJ_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = ADJ_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] adj_pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam int unsigned   PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == P_LAST);

  // Shared prescaler: counts 0..TICK_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    adj_debounce #(
      .DB_TICKS    (DB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_db (
      .i_clk  (clk),
      .i_rst_n(reset_n),
      .i_btn  (btn_in[g]),
      .i_tick (w_tick),
      .o_pulse(adj_pulse[g]),
      .o_level(btn_level[g])
    );
  end

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Scoreboard bench for adj_button_conditioner (TICK_DIV=4, DB_TICKS=3,
// REPEAT_DELAY=5, REPEAT_RATE=2). Expected pulse cycles are derived from
// the tick grid after reset release and pushed when a press is driven.
module tb_adj_button_conditioner;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] adj_pulse;
  logic [N-1:0] btn_level;

  int cyc      = 0;
  int rst_rel  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int b;
    int c;
  } exp_t;
  exp_t sb[$];

  adj_button_conditioner #(
    .N_BTN       (N),
    .TICK_DIV    (TD),
    .DB_TICKS    (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .adj_pulse(adj_pulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // First tick-active edge at or after cycle c (ticks every TD after reset release).
  function automatic int next_tick(input int c);
    int t;
    t = c;
    while (t <= rst_rel || ((t - rst_rel) % TD) != 0) t++;
    return t;
  endfunction

  // Edge at which a level change driven after edge p is accepted.
  function automatic int settle(input int p);
    return next_tick(p + 3) + (DB - 1) * TD;
  endfunction

  function automatic void expect_press(input logic [N-1:0] mask, input int p, input int r);
    int f;
    int l;
    int t;
    f = settle(p);
    l = settle(r);
    for (int b = 0; b < N; b++) begin
      if (mask[b]) begin
        sb.push_back('{b, f});
`ifdef ADJ_AUTOREPEAT_EN
        t = f + RD * TD;
        while (t < l) begin
          sb.push_back('{b, t});
          t += RR * TD;
        end
`else
        t = l;
`endif
      end
    end
  endfunction

  // Drive point: 1 time unit after posedge c.
  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sample point: negedge following posedge c.
  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Every cycle out of reset, each pulse bit must match the scoreboard.
  always @(negedge clk) begin
    int hit;
    if (reset_n) begin
      for (int b = 0; b < N; b++) begin
        hit = 0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].b == b && sb[i].c == cyc) begin
            hit = 1;
            sb.delete(i);
            break;
          end
        end
        check($sformatf("adj_pulse[%0d]@%0d", b, cyc), int'(adj_pulse[b]), hit);
      end
    end
  end

  task automatic finish_release(input logic [N-1:0] mask, input int l);
    at_neg(l - 1);
    check("level_before_release", int'(btn_level), int'(mask));
    at_neg(l);
    check("level_after_release", int'(btn_level), 0);
    at_neg(l + 6);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_press(input logic [N-1:0] mask, input int hold, input int bounce_at);
    int p;
    int f;
    int l;
    p = cyc;
    btn_in = mask;
    f = settle(p);
    l = settle(p + hold);
    expect_press(mask, p, p + hold);
    at_neg(f - 1);
    check("level_pre_press", int'(btn_level), 0);
    at_neg(f);
    check("level_at_press", int'(btn_level), int'(mask));
    check("press_latency_in_11_14", int'((f - p) >= 11 && (f - p) <= 14), 1);
    if (bounce_at > 0) begin
      at_cyc(p + bounce_at);
      btn_in = btn_in & ~mask;
      at_cyc(p + bounce_at + 5);
      btn_in = mask;
      at_neg(p + bounce_at + 12);
      check("level_after_bounce", int'(btn_level), int'(mask));
    end
    at_cyc(p + hold);
    btn_in = '0;
    finish_release(mask, l);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int f;
    int last;
    int hi;

    repeat (3) @(negedge clk);
    check("rst_pulse", int'(adj_pulse), 0);
    check("rst_level", int'(btn_level), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_rel = cyc;
    at_cyc(cyc + 5);

    // Clean press on hours.
    do_press(3'b001, 40, 0);

    // Short glitch on minutes: must never be accepted.
    at_cyc(cyc + 3);
    p = cyc;
    btn_in[1] = 1'b1;
    at_cyc(p + 6);
    btn_in[1] = 1'b0;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (btn_level[1]) hi++;
    end
    check("glitch_level_hi_cycles", hi, 0);
    check("glitch_sb_empty", sb.size(), 0);

    // Long hold on seconds (auto-repeat cadence when enabled).
    at_cyc(cyc + 3);
    do_press(3'b100, 100, 0);

    // Simultaneous press on all buttons.
    at_cyc(cyc + 5);
    do_press(3'b111, 30, 0);

    // Release bounce while held.
    at_cyc(cyc + 5);
    do_press(3'b001, 80, 40);

    // Reset mid-operation with seconds held, then release reset still held.
    at_cyc(cyc + 5);
    p = cyc;
    btn_in = 3'b100;
    f = settle(p);
    sb.push_back('{2, f});
    last = f;
`ifdef ADJ_AUTOREPEAT_EN
    sb.push_back('{2, f + RD * TD});
    sb.push_back('{2, f + RD * TD + RR * TD});
    last = f + RD * TD + RR * TD;
`endif
    at_neg(last);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_pulse", int'(adj_pulse), 0);
    check("async_rst_level", int'(btn_level), 0);
    check("rst_sb_empty", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("in_rst_pulse", int'(adj_pulse), 0);
    check("in_rst_level", int'(btn_level), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_rel = cyc;
    p = cyc;
    f = settle(p);
    expect_press(3'b100, p, p + 40);
    at_neg(f - 1);
    check("post_rst_level_pre", int'(btn_level), 0);
    at_neg(f);
    check("post_rst_level_press", int'(btn_level), 4);
    at_cyc(p + 40);
    btn_in = '0;
    finish_release(3'b100, settle(p + 40));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adj_button_conditioner.md
# adj_button_conditioner

Conditions the raw time-adjust push-buttons (hours, minutes, seconds) before they reach the VGA clock core. Synchronises each asynchronous pin, debounces it against a shared millisecond-scale tick, and emits one-clock `adj_pulse` strobes that the core consumes as "increment this field" commands. Sits between the top-level `ui_in[2:0]` pins and the core's `adj_hrs` / `adj_min` / `adj_sec` inputs.

## Interface
- `N_BTN`, default 3: number of buttons. Bit 0 = hours, bit 1 = minutes, bit 2 = seconds.
- `TICK_DIV`, default 31500: clock cycles per tick (1 kHz at 31.5 MHz).
- `DB_TICKS`, default 8: consecutive ticks a changed input must hold before the level is accepted.
- `REPEAT_DELAY`, default 500: ticks from accepted press to first auto-repeat.
- `REPEAT_RATE`, default 100: ticks between subsequent auto-repeats.
- `clk` in 1: system/pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_in` in N_BTN: raw button pins; active-high; asynchronous to `clk`.
- `adj_pulse` out N_BTN: one-cycle increment strobe per button.
- `btn_level` out N_BTN: debounced button level.

## Operation
- Synchroniser: two flops per bit. `btn_sync` is `btn_in` delayed 2 clocks.
- Prescaler: one counter shared by all buttons, counting 0..TICK_DIV-1. `tick` is high for one cycle when the count equals TICK_DIV-1; the counter then wraps to 0.
- Debounce counter, per bit, updated only on `tick`:
  - If `btn_sync` == `btn_level`, clear the counter.
  - Otherwise increment it.
  - When the incremented value reaches DB_TICKS, toggle `btn_level` and clear the counter.
  - The counter is ceil(log2(DB_TICKS+1)) bits wide and cannot overflow.
- Press FSM, per bit, with states IDLE, HELD, REPEAT. Every transition happens on a `tick` cycle.
  - IDLE -> HELD when `btn_level` rises. `adj_pulse` is high in the same cycle that `btn_level` becomes 1, and the repeat counter is cleared.
  - HELD: the repeat counter increments each tick. When it reaches REPEAT_DELAY, pulse, clear the counter, and go to REPEAT.
  - REPEAT: the repeat counter increments each tick. When it reaches REPEAT_RATE, pulse and clear the counter.
  - HELD or REPEAT -> IDLE when `btn_level` falls. No pulse on release.
- Buttons are fully independent. Simultaneous presses pulse in the same cycle, with no priority.
- Glitches shorter than DB_TICKS ticks never change `btn_level` and never pulse.

## Timing
- Reset values: `adj_pulse`=0, `btn_level`=0, all FSMs IDLE, all counters 0, synchronisers 0.
- Press latency from a clean `btn_in` edge to `adj_pulse`: between (DB_TICKS-1)*TICK_DIV+3 and DB_TICKS*TICK_DIV+2 clocks, depending on tick phase. Release latency to `btn_level` falling has the same bounds.
- `adj_pulse` is exactly one clock wide. Pulses on the same bit are at least REPEAT_RATE*TICK_DIV clocks apart.
- Button held through reset release: reads as released at reset, then produces a normal press pulse after debounce. No pulse is generated during reset.
- Reset asserted mid-operation clears all state immediately (asynchronous). `adj_pulse` drops in the same instant.
- All outputs are registered.

## Configuration
- Macro `ADJ_AUTOREPEAT_EN`.
- Defined: HELD/REPEAT auto-repeat behaves as described under Operation.
- Undefined: the REPEAT state and repeat counters are not built. The FSM is IDLE/HELD only, and a held button gives exactly one pulse per press. REPEAT_DELAY and REPEAT_RATE are ignored.

## Structure
- Package `adj_pkg`:
  - `adj_state_t` enum (IDLE, HELD, REPEAT).
  - Default constants: `ADJ_TICK_DIV`, `ADJ_DB_TICKS`, `ADJ_REPEAT_DELAY`, `ADJ_REPEAT_RATE`, `ADJ_N_BTN`.
- Sub-module `adj_debounce`: one button's synchroniser, debounce counter and press FSM, taking `tick` as an input. Instantiated N_BTN times.
- The prescaler lives in the top level.

## Test plan
All scenarios use TICK_DIV=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Clean press: raise `btn_in[0]` and hold 40 clocks -> exactly one `adj_pulse[0]` within 11-14 clocks of the edge. `btn_level[0]`=1 from the pulse cycle on. Other bits stay 0.
- Glitch: pulse `btn_in[1]` high for 6 clocks -> no `adj_pulse`, `btn_level[1]` stays 0.
- Auto-repeat (macro defined): hold `btn_in[2]` for 100 clocks -> first pulse, second pulse 20 clocks later, then a pulse every 8 clocks. Release -> no further pulses once `btn_level[2]` falls. Macro undefined -> a single pulse only.
- Simultaneous press: raise all three bits on the same clock -> all three `adj_pulse` bits high in the same cycle.
- Reset mid-operation: assert `reset_n`=0 while in REPEAT -> all outputs 0 immediately. Release `reset_n` with the button still held -> one press pulse after 11-14 clocks.
- Release bounce: while held, drop `btn_in` for 5 clocks and restore it -> `btn_level` stays 1 with no extra pulse, and the repeat cadence is unaffected.
